// File: rtl/plcp_pkg.sv
// Shared types, field sizes and helpers for the 802.11a PLCP framer.
package plcp_pkg;

  localparam int SIGNAL_BITS  = 24;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SIGNAL,
    S_SERVICE,
    S_PSDU,
    S_TAIL,
    S_PAD
  } state_e;

  typedef struct packed {
    logic [3:0]  rate;
    logic [11:0] length;
    logic [7:0]  ndbps;
  } frame_req_t;

  // Zero marks an undefined rate code.
  function automatic logic [7:0] rate_to_ndbps(input logic [3:0] rate);
    case (rate)
      4'b1101: return 8'd24;
      4'b1111: return 8'd36;
      4'b0101: return 8'd48;
      4'b0111: return 8'd72;
      4'b1001: return 8'd96;
      4'b1011: return 8'd144;
      4'b0001: return 8'd192;
      4'b0011: return 8'd216;
      default: return 8'd0;
    endcase
  endfunction

  // Bit 23 goes out first; length is bit-reversed so its LSB leads.
  function automatic logic [SIGNAL_BITS-1:0] signal_word(input logic [3:0] rate,
                                                         input logic [11:0] len);
    logic [11:0] rev;
    for (int i = 0; i < 12; i++) rev[11-i] = len[i];
    return {rate, 1'b0, rev, ^{rate, len}, 6'b000000};
  endfunction

endpackage

// File: rtl/plcp_framer_if.sv
// PSDU bit stream from the upstream source: valid/ready, one bit per beat.
interface plcp_framer_if;
  logic InData;
  logic InValid;
  logic InReady;

  modport master (output InData, output InValid, input InReady);
  modport slave  (input InData, input InValid, output InReady);
endinterface

// File: rtl/plcp_framer_lfsr_scrambler.sv
// x^7+x^4+1 additive scrambler; out is combinational, state steps on advance.
module lfsr_scrambler #(
  parameter logic [6:0] RST_SEED = 7'h5D
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       advance,
  input  logic       in,
  output logic       out
);
  logic [6:0] r_lfsr;
  logic       w_fb;

  assign w_fb = r_lfsr[6] ^ r_lfsr[3];
  assign out  = in ^ w_fb;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        r_lfsr <= RST_SEED;
    else if (load)    r_lfsr <= seed;
    else if (advance) r_lfsr <= {r_lfsr[5:0], w_fb};
  end
endmodule

// File: rtl/plcp_framer.sv
// 802.11a PLCP frame builder: preamble, SIGNAL, scrambled data field, serial out.
module plcp_framer
  import plcp_pkg::*;
#(
  parameter int                       PREAMBLE_BITS    = 96,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = {12{8'hAA}},
  parameter logic [6:0]               SCRAMBLER_SEED   = 7'h5D,
  parameter int                       LENGTH_W         = 12
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [3:0]          Rate,
  input  logic [LENGTH_W-1:0] Length,
  plcp_framer_if.slave        In,
  output logic                Output,
  output logic                OutValid,
  output logic                Busy,
  output logic                Done,
  output logic                Error
);
  localparam int CNT_W = $clog2(PREAMBLE_BITS > SIGNAL_BITS ? PREAMBLE_BITS : SIGNAL_BITS);

  state_e           r_state, w_nstate;
  frame_req_t       r_req;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [16:0]      r_dcnt, w_dcnt_n;
  logic [7:0]       r_pcnt, w_pcnt_n, w_pcnt_inc;
  logic             r_out, r_oval, r_busy, r_done, r_err;
  logic [7:0]       w_ndbps;
  logic             w_idle, w_reject, w_accept;
  logic             w_emit, w_raw, w_scr, w_adv, w_load, w_last, w_ready, w_scr_out;
  logic [SIGNAL_BITS-1:0] w_sig;
  logic [16:0]      w_psdu_end, w_tail_end;

  // Busy lags the state by one edge; Start is only honoured once both are idle.
  assign w_ndbps    = rate_to_ndbps(Rate);
  assign w_idle     = (r_state == S_IDLE) && !r_busy;
  assign w_reject   = Start && w_idle && (w_ndbps == 8'd0 || Length == '0);
  assign w_accept   = Start && w_idle && !w_reject;

  assign w_sig      = signal_word(r_req.rate, r_req.length);
  assign w_psdu_end = 17'({r_req.length, 3'b000}) + 17'(SERVICE_BITS - 1);
  assign w_tail_end = w_psdu_end + 17'(TAIL_BITS);
  assign w_pcnt_inc = (r_pcnt == r_req.ndbps - 8'd1) ? 8'd0 : r_pcnt + 8'd1;

  assign In.InReady = w_ready;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_cnt_n  = r_cnt;
    w_dcnt_n = r_dcnt;
    w_pcnt_n = r_pcnt;
    w_emit   = 1'b0;
    w_raw    = 1'b0;
    w_scr    = 1'b0;
    w_adv    = 1'b0;
    w_load   = 1'b0;
    w_last   = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_nstate = S_PREAMBLE;
        w_cnt_n  = '0;
        w_dcnt_n = '0;
        w_pcnt_n = '0;
      end
      S_PREAMBLE: begin
        w_emit = 1'b1;
        w_raw  = PREAMBLE_PATTERN[CNT_W'(PREAMBLE_BITS - 1) - r_cnt];
        if (r_cnt == CNT_W'(PREAMBLE_BITS - 1)) begin
          w_nstate = S_SIGNAL;
          w_cnt_n  = '0;
        end else w_cnt_n = r_cnt + CNT_W'(1);
      end
      S_SIGNAL: begin
        w_emit = 1'b1;
        w_raw  = w_sig[5'(SIGNAL_BITS - 1) - r_cnt[4:0]];
        if (r_cnt == CNT_W'(SIGNAL_BITS - 1)) begin
          w_nstate = S_SERVICE;
          w_load   = 1'b1;
        end else w_cnt_n = r_cnt + CNT_W'(1);
      end
      S_SERVICE: begin
        w_emit   = 1'b1;
        w_scr    = 1'b1;
        w_adv    = 1'b1;
        w_dcnt_n = r_dcnt + 17'd1;
        w_pcnt_n = w_pcnt_inc;
        if (r_dcnt == 17'(SERVICE_BITS - 1)) w_nstate = S_PSDU;
      end
      S_PSDU: begin
        w_ready = 1'b1;
        if (In.InValid) begin
          w_emit   = 1'b1;
          w_scr    = 1'b1;
          w_adv    = 1'b1;
          w_raw    = In.InData;
          w_dcnt_n = r_dcnt + 17'd1;
          w_pcnt_n = w_pcnt_inc;
          if (r_dcnt == w_psdu_end) w_nstate = S_TAIL;
        end
      end
      S_TAIL: begin
        // Tail leaves as zeros but still steps the LFSR to keep PAD aligned.
        w_emit   = 1'b1;
        w_adv    = 1'b1;
        w_dcnt_n = r_dcnt + 17'd1;
        w_pcnt_n = w_pcnt_inc;
        if (r_dcnt == w_tail_end) w_nstate = S_PAD;
      end
      S_PAD: begin
        w_emit   = 1'b1;
        w_scr    = 1'b1;
        w_adv    = 1'b1;
        w_dcnt_n = r_dcnt + 17'd1;
        w_pcnt_n = w_pcnt_inc;
        if (w_pcnt_inc == 8'd0) begin
          w_last   = 1'b1;
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt  <= '0;
      r_dcnt <= '0;
      r_pcnt <= '0;
      r_req  <= '0;
      r_out  <= 1'b0;
      r_oval <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_n;
      r_dcnt <= w_dcnt_n;
      r_pcnt <= w_pcnt_n;
      if (w_accept) r_req <= '{rate: Rate, length: 12'(Length), ndbps: w_ndbps};
      r_out  <= w_emit & (w_scr ? w_scr_out : w_raw);
      r_oval <= w_emit;
      r_busy <= (r_state != S_IDLE);
      r_done <= w_last;
      r_err  <= w_reject;
    end
  end

  lfsr_scrambler #(.RST_SEED(SCRAMBLER_SEED)) u_scr (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (w_load),
    .seed    (SCRAMBLER_SEED),
    .advance (w_adv),
    .in      (w_raw),
    .out     (w_scr_out)
  );

  assign Output   = r_out;
  assign OutValid = r_oval;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Error    = r_err;
endmodule

// File: tb/tb_plcp_framer.sv
// Directed bench for plcp_framer: golden bit model plus hand-computed frame facts.
module tb_plcp_framer;
  logic        Clock, Reset, Start;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic Output1, OutValid1, Busy1, Done1, Error1;
  logic Output2, OutValid2, Busy2, Done2, Error2;

  plcp_framer_if bus1();
  plcp_framer_if bus2();
  assign bus2.InData  = bus1.InData;
  assign bus2.InValid = bus1.InValid;

  plcp_framer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
    .In(bus1), .Output(Output1), .OutValid(OutValid1), .Busy(Busy1),
    .Done(Done1), .Error(Error1)
  );

  plcp_framer #(.SCRAMBLER_SEED(7'h7F)) dut_s7f (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
    .In(bus2), .Output(Output2), .OutValid(OutValid2), .Busy(Busy2),
    .Done(Done2), .Error(Error2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic got_q[$];
  logic got2_q[$];
  logic exp_q[$];
  logic gold_q[$];
  int   done_cyc, low_cyc, gaps, errs, dones;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic psdu_bit(input int b);
    logic [7:0] by;
    by = 8'((b / 8) * 37 + 5);
    return by[b % 8];
  endfunction

  function automatic int ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 24;  4'b1111: return 36;  4'b0101: return 48;  4'b0111: return 72;
      4'b1001: return 96;  4'b1011: return 144; 4'b0001: return 192; 4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic build_exp(input logic [3:0] rate, input int len, input logic [6:0] seed);
    logic [95:0] pre;
    logic [11:0] l;
    logic [6:0]  st;
    logic        par, s, d;
    int          nd, ndata;
    pre = {12{8'hAA}};
    l   = 12'(len);
    exp_q.delete();
    for (int i = 0; i < 96; i++) exp_q.push_back(pre[95-i]);
    par = 1'b0;
    for (int i = 3; i >= 0; i--) begin exp_q.push_back(rate[i]); par ^= rate[i]; end
    exp_q.push_back(1'b0);
    for (int i = 0; i < 12; i++) begin exp_q.push_back(l[i]); par ^= l[i]; end
    exp_q.push_back(par);
    for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
    nd    = ndbps_of(rate);
    ndata = nd * ((22 + 8 * len + nd - 1) / nd);
    st    = seed;
    for (int k = 0; k < ndata; k++) begin
      s  = st[6] ^ st[3];
      st = {st[5:0], s};
      d  = (k >= 16 && k < 16 + 8 * len) ? psdu_bit(k - 16) : 1'b0;
      if (k >= 16 + 8 * len && k < 22 + 8 * len) exp_q.push_back(1'b0);
      else exp_q.push_back(d ^ s);
    end
  endtask

  function automatic int diff_exp();
    int n;
    n = (got_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // Sample index c counts edges after the one that samples Start.
  task automatic run_frame(input logic [3:0] rate, input int len, input int stall_at,
                           input int nstall, input int stop_at);
    int idx, left;
    bit taken, seen;
    got_q.delete(); got2_q.delete();
    done_cyc = -1; low_cyc = -1; gaps = 0; errs = 0; dones = 0;
    idx = 0; left = nstall; taken = 0; seen = 0;
    @(negedge Clock);
    Start = 1'b1; Rate = rate; Length = 12'(len);
    for (int c = 0; c <= 1200; c++) begin
      @(negedge Clock);
      if (taken) idx++;
      if (OutValid1) begin
        got_q.push_back(Output1);
        got2_q.push_back(Output2);
        seen = 1;
      end else if (seen && done_cyc < 0 && Busy1) gaps++;
      if (Error1) errs++;
      if (Done1) begin dones++; done_cyc = c; end
      if (done_cyc >= 0 && !Busy1) begin low_cyc = c; break; end
      if (c == stop_at) break;
      Start = (c == 50);
      Rate  = (c == 50) ? 4'b0000 : rate;
      if (bus1.InReady && idx == stall_at && left > 0) begin
        bus1.InValid = 1'b0;
        left--;
      end else bus1.InValid = 1'b1;
      bus1.InData = psdu_bit(idx);
      taken = bus1.InValid && bus1.InReady;
    end
    Start = 1'b0;
  endtask

  task automatic reject_req(input string tag, input logic [3:0] rate, input int len);
    @(negedge Clock);
    Start = 1'b1; Rate = rate; Length = 12'(len);
    @(negedge Clock);
    Start = 1'b0;
    check({tag, "_err"}, 32'(Error1), 32'd1);
    check({tag, "_idle"}, 32'({Busy1, OutValid1, bus1.InReady}), 32'd0);
    @(negedge Clock);
    check({tag, "_pulse"}, 32'({Error1, Busy1, OutValid1, bus1.InReady}), 32'd0);
  endtask

  initial begin
    logic [23:0] sig;
    logic [15:0] svc;
    logic [5:0]  tail;
    int          pm;
    Reset = 1'b1; Start = 1'b0; Rate = 4'b0000; Length = '0;
    bus1.InData = 1'b0; bus1.InValid = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_outs", 32'({Output1, OutValid1, Busy1, Done1, Error1, bus1.InReady,
                             Output2, OutValid2, Busy2, Done2, Error2}), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("post_reset_idle", 32'({OutValid1, Busy1, Done1, Error1, bus1.InReady}), 32'd0);

    // Rate 1101, 16 octets, with a Start/bad-rate poke mid-frame that must be ignored
    run_frame(4'b1101, 16, -1, 0, -1);
    pm = 0;
    for (int i = 0; i < 96; i++) if (got_q[i] !== (i % 2 == 0)) pm++;
    check("preamble", 32'(pm), 32'd0);
    sig = '0;
    for (int i = 96; i < 120; i++) sig = {sig[22:0], got_q[i]};
    check("signal", 32'(sig), 32'(24'b1101_0_000010000000_0_000000));
    svc = '0;
    for (int i = 120; i < 136; i++) svc = {svc[14:0], got2_q[i]};
    check("service_seed7f", 32'(svc), 32'(16'b0000111011110010));
    check("a_done_cyc", done_cyc, 288);
    check("a_busy_low", low_cyc, 289);
    check("a_gaps", gaps, 0);
    check("a_busy_start_no_err", errs, 0);
    check("a_bits", got_q.size(), 288);
    build_exp(4'b1101, 16, 7'h5D);
    check("a_model", diff_exp(), 0);
    gold_q = got_q;

    // Same frame with a 3-cycle source stall
    run_frame(4'b1101, 16, 40, 3, -1);
    check("stall_gaps", gaps, 3);
    check("stall_done_cyc", done_cyc, 291);
    exp_q = gold_q;
    check("stall_same_bits", diff_exp(), 0);

    reject_req("rej_rate", 4'b0000, 16);
    reject_req("rej_len0", 4'b1101, 0);

    // Rate 0011, 100 octets: N_DATA 864, 42 pad bits
    run_frame(4'b0011, 100, -1, 0, -1);
    check("b_done_cyc", done_cyc, 984);
    tail = '0;
    for (int i = 936; i < 942; i++) tail = {tail[4:0], got_q[i]};
    check("b_tail_zero", 32'(tail), 32'd0);
    build_exp(4'b0011, 100, 7'h5D);
    check("b_model", diff_exp(), 0);

    // Abort mid-PSDU with an asynchronous reset, then a clean frame
    run_frame(4'b0101, 8, -1, 0, 150);
    check("pre_rst_valid", 32'(OutValid1), 32'd1);
    check("pre_rst_nodone", dones, 0);
    #2 Reset = 1'b1;
    #1 check("rst_async", 32'({Output1, OutValid1, Busy1, Done1, Error1, bus1.InReady}), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    run_frame(4'b0101, 8, -1, 0, -1);
    check("c_done_cyc", done_cyc, 216);
    build_exp(4'b0101, 8, 7'h5D);
    check("c_model", diff_exp(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/plcp_framer.md
# plcp_framer

Parametrised 802.11a PLCP frame builder, the successor to the fixed-rate serial transmitter. Rate and PSDU length are latched per frame from ports, and N_DBPS is derived from the rate. PSDU bits are pulled from an upstream source through a valid/ready handshake. The block emits one serial bit per cycle, with a valid qualifier, to the convolutional encoder stage. The data-field tail is zeroed after scrambling, as the standard requires.

## Interface
- PREAMBLE_BITS, 96: number of preamble bits sent before SIGNAL.
- PREAMBLE_PATTERN, {12{8'hAA}}: preamble bits; bit [PREAMBLE_BITS-1] is sent first.
- SCRAMBLER_SEED, 7'h5D: LFSR state loaded at the start of SERVICE; must be nonzero.
- LENGTH_W, 12: width of Length.
- Clock  in  1  clock.
- Reset  in  1  reset, asynchronous, active-high.
- Start  in  1  one-cycle frame request; sampled only in IDLE.
- Rate  in  4  {R1,R2,R3,R4}; Rate[3] = R1 is sent first.
- Length  in  LENGTH_W  PSDU octets, 1..2^LENGTH_W-1.
- InData  in  1  PSDU bit, LSB of each octet first.
- InValid  in  1  InData valid.
- InReady  out  1  block consumes InData this cycle when InValid && InReady.
- Output  out  1  serial frame bit.
- OutValid  out  1  Output valid.
- Busy  out  1  frame in progress.
- Done  out  1  one-cycle pulse, coincident with the last bit of the frame.
- Error  out  1  one-cycle pulse when a Start is rejected.

## Operation
- Reset: all outputs 0, state IDLE, counters 0, LFSR = SCRAMBLER_SEED.
- IDLE with Start: Rate decodes to N_DBPS as follows.
  - 1101→24, 1111→36, 0101→48, 0111→72.
  - 1001→96, 1011→144, 0001→192, 0011→216.
- Rejected Start: an undefined Rate or Length==0 → Error, stay IDLE.
- Accepted Start: latch Rate, Length and N_DBPS; go to PREAMBLE.
- Start while Busy is ignored; no Error is raised.
- States, in order: IDLE → PREAMBLE → SIGNAL → SERVICE → PSDU → TAIL → PAD → IDLE.
- PREAMBLE: PREAMBLE_BITS bits, unscrambled.
- SIGNAL: 24 bits, unscrambled, in this order:
  - R1..R4;
  - reserved 0;
  - Length bits 0..11, LSB first;
  - even parity over the preceding 17 bits;
  - 6 zeros.
- SERVICE: 16 zeros, scrambled. LFSR is loaded with SCRAMBLER_SEED on SIGNAL→SERVICE.
- PSDU: 8·Length bits, scrambled. InReady=1 only in this state.
  - A cycle with InValid=0 is a stall: OutValid=0 on the following cycle.
  - During a stall, the LFSR, counters and state hold.
- TAIL: 6 bits forced to 0, not scrambled. The LFSR still advances.
- PAD: scrambled zeros until the data-bit count is a multiple of N_DBPS.
  - N_DATA = N_DBPS·ceil((22+8·Length)/N_DBPS).
- Scrambler: x^7+x^4+1. Each cycle the feedback bit s = x7^x4 is computed from the current state; the state shifts with s as the new bit, and out = in^s. It advances only on emitted data-field bits.
- Arithmetic:
  - Data-bit counter is 17 bits wide; the pad counter counts modulo N_DBPS (8 bits).
  - With no stalls, total frame = PREAMBLE_BITS + 24 + N_DATA cycles.

## Timing
- Start sampled at edge k. Busy=1 and the first preamble bit (OutValid=1) appear after edge k+1.
- Output and OutValid are registered. A PSDU bit accepted at edge j appears after edge j+1.
- Done and the last PAD bit appear together after the same edge. Busy falls on the next edge.
- A new Start is accepted on the first cycle Busy=0.
- Reset mid-frame: outputs go to 0 immediately, the frame is abandoned, and no Done is raised.

## Structure
- Package plcp_pkg:
  - state enum;
  - rate→N_DBPS function;
  - SIGNAL_BITS=24, SERVICE_BITS=16, TAIL_BITS=6.
- Sub-module lfsr_scrambler: ports load, seed, advance, in, out.

## Test plan
- Rate=1101, Length=16, SEED default, no stalls →
  - 96 alternating bits starting 1;
  - SIGNAL 1101 0 000010000000 0 000000;
  - N_DATA=168 (18 pad bits); Done at cycle 288; Busy low at cycle 289.
- SCRAMBLER_SEED=7'h7F → first 16 SERVICE bits are 0000111011110010.
- Stall: InValid=0 for 3 cycles mid-PSDU →
  - exactly 3 OutValid=0 gaps;
  - serial bit sequence identical to the no-stall run;
  - frame lasts 291 cycles.
- Rejected requests: Rate=0000, then Length=0 → Error pulse each time; Busy, OutValid and InReady stay 0.
- Rate=0011, Length=100 → N_DATA=864 (42 pad bits); 6 tail bits all 0; total 984 cycles.
- Reset asserted mid-PSDU, then a new Start → outputs go to 0 at once; the second frame is bit-exact with the golden model.
